serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor computing D = A - B - Bin, LSB first, one bit per clock.
- Sequential inverse counterpart of the lab's parallel adder; used where area matters more than latency.
- Operands are captured on a start pulse; the result is flagged by a one-cycle done pulse.
- The result holds stable until the next accepted start.

Parameters:
- WIDTH, 8, operand and result width in bits (valid range ≥ 2).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  minuend; captured on the accepted start edge.
- B  input  WIDTH  subtrahend; captured on the accepted start edge.
- Bin  input  1  borrow-in; captured on the accepted start edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse in DONE.
- D  output  WIDTH  difference (A - B - Bin) mod 2^WIDTH.
- Bout  output  1  borrow-out; 1 iff A < B + Bin (unsigned).

Behaviour:
- Reset (rst=1, asynchronous, any state): state=IDLE; busy=0, done=0, D=0, Bout=0; internal shift registers, borrow flop and bit counter cleared.
- States and transitions:
  - IDLE -> RUN when start=1 at a rising edge.
  - RUN -> DONE after WIDTH RUN edges.
  - DONE -> IDLE unconditionally on the next edge.
- Accept edge N (IDLE, start=1):
  - Load a_sh<=A, b_sh<=B, br<=Bin, cnt<=0; state<=RUN.
  - D and Bout keep their previous values until RUN writes them.
- Each RUN edge processes a0=a_sh[0], b0=b_sh[0]:
  - d = a0 ^ b0 ^ br.
  - br <= (~a0 & b0) | (~(a0 ^ b0) & br).
  - a_sh, b_sh shift right by 1.
  - D shifts right with d entering at D[WIDTH-1].
  - cnt increments.
- On the RUN edge where cnt = WIDTH-1 (edge N+WIDTH):
  - Last bit processed; Bout <= final borrow; state<=DONE.
- Latency: done=1 between edges N+WIDTH and N+WIDTH+1. D and Bout are valid from edge N+WIDTH and stable until the next accept edge.
- Output decode: busy = (state==RUN); done = (state==DONE). Both are registered-state decodes with no combinational path from inputs.
- D during RUN is a partial shift value and must not be sampled; consumers use done.
- Ignored starts: start in RUN or DONE is ignored, with no queuing. start held high continuously re-triggers at the first IDLE edge, i.e. one edge after DONE.
- Width rule: cnt is clog2(WIDTH) bits wide. Wrap-around is mod 2^WIDTH, e.g. 0x00 - 0x01 = 0xFF with Bout=1.
- Input stability: A/B/Bin changes after the accept edge have no effect on the current operation.
- Reset mid-RUN: aborts immediately to reset values; no done pulse is produced for the aborted operation.

Test Plan:
- Reset, then A=0xAA, B=0x55, Bin=0, start 1 cycle -> busy high 8 cycles; done pulses at start edge+8; D=0x55, Bout=0.
- A=0x01, B=0x01, Bin=1 -> D=0xFF, Bout=1; A=0x00, B=0xFF, Bin=0 -> D=0x01, Bout=1.
- A=0x66, B=0x11, Bin=0 -> D=0x55, Bout=0; A=0xFF, B=0x00, Bin=1 -> D=0xFE, Bout=0. Verify D/Bout stay stable after done until the next start.
- Start at edge N with A=0x10, B=0x01; pulse start again with A=0x00, B=0x00 at edges N+3 and N+8 (DONE) -> both ignored; D=0x0F, Bout=0; busy=0 at edge N+9.
- Assert rst asynchronously (between edges) at edge N+4 of an operation -> busy, done, D, Bout go 0 immediately; no done pulse follows; a new start then completes correctly.
- start held high continuously with A=0x80, B=0x7F, Bin=0 -> back-to-back results D=0x01, Bout=0; done pulses spaced exactly WIDTH+2 cycles apart.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - Bin, LSB first, one bit per clock.
// Operands are captured on an accepted start. Completion is marked by a
// one-cycle done pulse. D and Bout then hold until the next accepted start.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] D,
   output logic             Bout
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic             br_q, br_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             bout_q, bout_d;
   logic             busy_q, done_q;

   logic a0, b0, diff_bit, br_next;

   // One full-subtractor slice on the current LSBs
   always_comb begin
      a0       = a_sh_q[0];
      b0       = b_sh_q[0];
      diff_bit = a0 ^ b0 ^ br_q;
      br_next  = (~a0 & b0) | (~(a0 ^ b0) & br_q);
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      d_d     = d_q;
      bout_d  = bout_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_sh_d  = A;
               b_sh_d  = B;
               br_d    = Bin;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            br_d   = br_next;
            d_d    = {diff_bit, d_q[WIDTH-1:1]};
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               bout_d  = br_next;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, datapath and status registers; status mirrors the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         d_q     <= '0;
         bout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         d_q     <= d_d;
         bout_q  <= bout_d;
         busy_q  <= (state_d == RUN);
         done_q  <= (state_d == DONE);
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign D    = d_q;
   assign Bout = bout_q;

endmodule
